// File: rtl/sram_scheduler4_pkg.sv
// Shared definitions for the four-requester SRAM scheduler: defaults, state codes, helpers.
package sram_scheduler4_pkg;

    localparam int unsigned DefAddrWidth  = 17;
    localparam int unsigned DefDataWidth  = 8;
    localparam int unsigned DefWaitCycles = 2;

    typedef logic [1:0] state_t;

    localparam state_t StIdle   = 2'd0;
    localparam state_t StSetup  = 2'd1;
    localparam state_t StAccess = 2'd2;
    localparam state_t StDone   = 2'd3;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/sram_scheduler4_rr_pick4.sv
// Combinational round-robin picker: first requester after last_i, wrapping mod 4.
module rr_pick4 (
    input  logic [3:0] req_i,
    input  logic [1:0] last_i,
    output logic [1:0] grant_o,
    output logic       valid_o
);

    logic [1:0] idx;

    always_comb begin
        grant_o = last_i;
        valid_o = 1'b0;
        idx     = last_i;
        // k = 4 wraps back to last_i, so a lone repeat requester still wins.
        for (int k = 1; k <= 4; k++) begin
            idx = last_i + 2'(k);
            if (!valid_o && req_i[idx]) begin
                grant_o = idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_scheduler4.sv
// Four-port round-robin scheduler driving an asynchronous SRAM with registered strobes.
module sram_scheduler4
    import sram_scheduler4_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
    parameter int unsigned DATA_WIDTH  = DefDataWidth,
    parameter int unsigned WAIT_CYCLES = DefWaitCycles
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              dev_req,
    input  logic [3:0]              dev_we,
    input  logic [4*ADDR_WIDTH-1:0] dev_addr,
    input  logic [4*DATA_WIDTH-1:0] dev_wdata,
    output logic [3:0]              dev_done,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_dout,
    output logic                    sram_doe,
    input  logic [DATA_WIDTH-1:0]   sram_din,
    output logic                    sram_ce_n,
    output logic                    sram_oe_n,
    output logic                    sram_we_n
);

    localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [1:0]              grant_q;
    logic                    we_q, we_d;
    logic [3:0]              done_q, done_d;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   dout_q;
    logic                    doe_q, doe_d;
    logic                    ce_n_q, ce_n_d;
    logic                    oe_n_q, oe_n_d;
    logic                    we_n_q, we_n_d;

    logic [1:0]              pick_idx;
    logic                    pick_valid;
    logic                    grab;
    logic                    last_access;

    rr_pick4 u_pick (
        .req_i   (dev_req),
        .last_i  (grant_q),
        .grant_o (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        grab        = (state_q == StIdle) && pick_valid;
        we_d        = grab ? dev_we[pick_idx] : we_q;
        last_access = (state_q == StAccess) && (cnt_q == LastCnt);
        state_d     = state_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            StIdle:   if (pick_valid) state_d = StSetup;
            StSetup: begin
                state_d = StAccess;
                cnt_d   = 4'd0;
            end
            StAccess: begin
                if (last_access) begin
                    state_d = StDone;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        // Strobes are registered from the next state so they line up with state_q.
        ce_n_d = (state_d == StIdle);
        oe_n_d = !(((state_d == StSetup) || (state_d == StAccess)) && !we_d);
        we_n_d = !((state_d == StAccess) && we_d);
        doe_d  = (state_d != StIdle) && we_d;
        done_d = (state_d == StDone) ? onehot4(grant_q) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            grant_q <= 2'd3;
            we_q    <= 1'b0;
            done_q  <= 4'b0000;
            rdata_q <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            doe_q   <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            done_q  <= done_d;
            doe_q   <= doe_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            if (grab) begin
                grant_q <= pick_idx;
                addr_q  <= dev_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                dout_q  <= dev_wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (last_access && !we_q) begin
                rdata_q <= sram_din;
            end
        end
    end

    assign dev_done  = done_q;
    assign rdata     = rdata_q;
    assign sram_addr = addr_q;
    assign sram_dout = dout_q;
    assign sram_doe  = doe_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;

endmodule

// File: tb/tb_sram_scheduler4.sv
// Directed bench for sram_scheduler4: default-timing instance plus a WAIT_CYCLES=15 instance.
module tb_sram_scheduler4;

    localparam int AW = 17;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]      dev_req = '0, dev_we = '0;
    logic [4*AW-1:0] dev_addr = '0;
    logic [4*DW-1:0] dev_wdata = '0;
    logic [DW-1:0]   sram_din = '0;
    logic [3:0]      dev_done;
    logic [DW-1:0]   rdata, sram_dout;
    logic [AW-1:0]   sram_addr;
    logic            sram_doe, ce_n, oe_n, we_n;

    logic [3:0]      req_l = '0, we_l = '0;
    logic [4*AW-1:0] addr_l = '0;
    logic [4*DW-1:0] wdata_l = '0;
    logic [DW-1:0]   din_l = '0;
    logic [3:0]      done_l;
    logic [DW-1:0]   rdata_l, dout_l;
    logic [AW-1:0]   saddr_l;
    logic            doe_l, ce_n_l, oe_n_l, we_n_l;

    sram_scheduler4 dut (
        .clk(clk), .reset(reset), .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr),
        .dev_wdata(dev_wdata), .dev_done(dev_done), .rdata(rdata), .sram_addr(sram_addr),
        .sram_dout(sram_dout), .sram_doe(sram_doe), .sram_din(sram_din),
        .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n)
    );

    sram_scheduler4 #(.WAIT_CYCLES(15)) dut_long (
        .clk(clk), .reset(reset), .dev_req(req_l), .dev_we(we_l), .dev_addr(addr_l),
        .dev_wdata(wdata_l), .dev_done(done_l), .rdata(rdata_l), .sram_addr(saddr_l),
        .sram_dout(dout_l), .sram_doe(doe_l), .sram_din(din_l),
        .sram_ce_n(ce_n_l), .sram_oe_n(oe_n_l), .sram_we_n(we_n_l)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int         m_done_at, m_oe, m_we, m_doe, m_ce;
    logic [3:0] m_done_val;
    logic [7:0] m_rdata, m_dout;

    // Present req in the current IDLE cycle (cycle 0) and watch until the done pulse.
    task automatic run_xfer(input logic [3:0] req);
        dev_req = req;
        m_done_at = -1; m_oe = 0; m_we = 0; m_doe = 0; m_ce = 0;
        m_done_val = '0; m_rdata = '0; m_dout = '0;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (!oe_n) m_oe++;
            if (!we_n) m_we++;
            if (sram_doe) m_doe++;
            if (!ce_n) m_ce++;
            if (dev_done != 4'b0) begin
                m_done_at = k; m_done_val = dev_done; m_rdata = rdata; m_dout = sram_dout;
                dev_req = '0;
                break;
            end
        end
        tick;
    endtask

    task automatic wait_done(input int budget, output int cyc, output logic [3:0] val);
        cyc = -1;
        val = '0;
        for (int k = 1; k <= budget; k++) begin
            tick;
            if (dev_done != 4'b0) begin
                cyc = k; val = dev_done;
                break;
            end
        end
    endtask

    int         c;
    logic [3:0] v;
    logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        reset = 1'b0;
        tick; tick;
        check_eq("rst_ce_n", 32'(ce_n), 1);
        check_eq("rst_oe_n", 32'(oe_n), 1);
        check_eq("rst_we_n", 32'(we_n), 1);
        check_eq("rst_doe", 32'(sram_doe), 0);
        check_eq("rst_addr", 32'(sram_addr), 0);
        check_eq("rst_dout", 32'(sram_dout), 0);
        check_eq("rst_rdata", 32'(rdata), 0);
        check_eq("rst_done", 32'(dev_done), 0);
        reset = 1'b1;
        tick;

        // Device 2 read
        dev_we = 4'b0000;
        dev_addr[2*AW +: AW] = 17'h00155;
        sram_din = 8'hA5;
        run_xfer(4'b0100);
        check_eq("rd_done_cycle", 32'(m_done_at), 4);
        check_eq("rd_done_val", 32'(m_done_val), 32'h4);
        check_eq("rd_rdata", 32'(m_rdata), 32'hA5);
        check_eq("rd_oe_cycles", 32'(m_oe), 3);
        check_eq("rd_we_cycles", 32'(m_we), 0);
        check_eq("rd_doe_cycles", 32'(m_doe), 0);
        check_eq("rd_ce_cycles", 32'(m_ce), 4);
        check_eq("rd_idle_ce_n", 32'(ce_n), 1);
        check_eq("rd_idle_addr_hold", 32'(sram_addr), 32'h155);

        // Device 0 write
        dev_we = 4'b0001;
        dev_addr[0 +: AW] = 17'h00010;
        dev_wdata[0 +: DW] = 8'h3C;
        sram_din = 8'h77;
        run_xfer(4'b0001);
        check_eq("wr_done_cycle", 32'(m_done_at), 4);
        check_eq("wr_done_val", 32'(m_done_val), 32'h1);
        check_eq("wr_we_cycles", 32'(m_we), 2);
        check_eq("wr_doe_cycles", 32'(m_doe), 4);
        check_eq("wr_oe_cycles", 32'(m_oe), 0);
        check_eq("wr_dout", 32'(m_dout), 32'h3C);
        check_eq("wr_rdata_keep", 32'(m_rdata), 32'hA5);
        check_eq("wr_idle_doe", 32'(sram_doe), 0);
        check_eq("wr_idle_we_n", 32'(we_n), 1);
        check_eq("wr_idle_addr_hold", 32'(sram_addr), 32'h10);
        check_eq("wr_idle_rdata_keep", 32'(rdata), 32'hA5);

        // Device 3 arrives while device 1 is in ACCESS
        dev_we = 4'b0000;
        dev_addr[1*AW +: AW] = 17'h01111;
        dev_addr[3*AW +: AW] = 17'h03333;
        sram_din = 8'h11;
        dev_req = 4'b0010;
        tick;
        check_eq("ovl_setup_addr", 32'(sram_addr), 32'h1111);
        tick;
        dev_req = 4'b1010;
        wait_done(10, c, v);
        check_eq("ovl_dev1_cycle", 32'(c), 2);
        check_eq("ovl_dev1_val", 32'(v), 32'h2);
        check_eq("ovl_dev1_rdata", 32'(rdata), 32'h11);
        check_eq("ovl_dev1_addr", 32'(sram_addr), 32'h1111);
        dev_req = 4'b1000;
        sram_din = 8'h33;
        wait_done(10, c, v);
        check_eq("ovl_dev3_cycle", 32'(c), 5);
        check_eq("ovl_dev3_val", 32'(v), 32'h8);
        check_eq("ovl_dev3_addr", 32'(sram_addr), 32'h3333);
        check_eq("ovl_dev3_rdata", 32'(rdata), 32'h33);
        dev_req = '0;
        tick;

        // Reset on first ACCESS cycle of a device 1 write
        dev_we = 4'b0010;
        dev_wdata[1*DW +: DW] = 8'hEE;
        dev_req = 4'b0010;
        tick;
        check_eq("abort_setup_doe", 32'(sram_doe), 1);
        tick;
        check_eq("abort_access_we_n", 32'(we_n), 0);
        reset = 1'b0;
        tick;
        check_eq("abort_we_n", 32'(we_n), 1);
        check_eq("abort_doe", 32'(sram_doe), 0);
        check_eq("abort_ce_n", 32'(ce_n), 1);
        check_eq("abort_no_done", 32'(dev_done), 0);
        reset = 1'b1;

        // All four held high: round-robin from device 0, five cycles apart
        dev_we = 4'b0000;
        sram_din = 8'h42;
        dev_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_done(12, c, v);
            check_eq($sformatf("rr_grant%0d", i), 32'(v), 32'(rr_exp[i]));
            check_eq($sformatf("rr_gap%0d", i), 32'(c), (i == 0) ? 32'd4 : 32'd5);
        end
        dev_req = '0;
        tick; tick;

        // Long-wait instance: done at N+17, counter runs the full 15 ACCESS cycles
        we_l = 4'b0000;
        addr_l[0 +: AW] = 17'h1ABCD;
        din_l = 8'h5A;
        req_l = 4'b0001;
        m_done_at = -1; m_oe = 0; m_done_val = '0; m_rdata = '0;
        for (int k = 1; k <= 25; k++) begin
            tick;
            if (!oe_n_l) m_oe++;
            if (done_l != 4'b0) begin
                m_done_at = k; m_done_val = done_l; m_rdata = rdata_l;
                req_l = '0;
                break;
            end
        end
        check_eq("long_done_cycle", 32'(m_done_at), 17);
        check_eq("long_done_val", 32'(m_done_val), 32'h1);
        check_eq("long_oe_cycles", 32'(m_oe), 16);
        check_eq("long_rdata", 32'(m_rdata), 32'h5A);
        check_eq("long_addr", 32'(saddr_l), 32'h1ABCD);
        tick;
        check_eq("long_idle_ce_n", 32'(ce_n_l), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
